// File: rtl/mips_decode_stage.sv
// ============================================================================
// Module  : mips_decode_stage
// Brief   : MIPS instruction decode with RAW scoreboard, writeback bypass and
//           a one-entry registered output stage toward execute.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_decode_stage #(
  parameter int BYPASS_EN = 1,
  parameter int RA_REG    = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        signal_reg_write,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dest,
  output logic        id_reg_write,
  output logic        id_illegal
);

  localparam logic       c_bypass = (BYPASS_EN != 0);
  localparam logic [4:0] c_ra_reg = RA_REG[4:0];

  wire logic [5:0]  w_opcode = instr[31:26];
  wire logic [4:0]  w_rs     = instr[25:21];
  wire logic [4:0]  w_rt     = instr[20:16];
  wire logic [4:0]  w_rd     = instr[15:11];
  wire logic [5:0]  w_funct  = instr[5:0];

  logic        w_use_rs;
  logic        w_use_rt;
  logic [4:0]  w_dest;
  logic        w_rw_raw;
  logic        w_illegal;
  logic        w_zext;
  logic        w_reg_write;
  logic [31:0] w_imm;

  logic        r_id_valid;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_dest;
  logic        r_reg_write;
  logic        r_illegal;
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;

  // Field decode: which sources are read, where the result goes.
  always_comb begin
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_dest    = 5'd0;
    w_rw_raw  = 1'b0;
    w_illegal = 1'b0;
    w_zext    = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_use_rs = 1'b1;
        if (w_funct != 6'h08) begin
          w_use_rt = 1'b1;
          w_dest   = w_rd;
          w_rw_raw = 1'b1;
        end
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h23: begin
        w_use_rs = 1'b1;
        w_dest   = w_rt;
        w_rw_raw = 1'b1;
        w_zext   = (w_opcode == 6'h0C) || (w_opcode == 6'h0D);
      end
      6'h0F: begin
        w_dest   = w_rt;
        w_rw_raw = 1'b1;
      end
      6'h2B, 6'h04, 6'h05: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      6'h02: ;
      6'h03: begin
        w_dest   = c_ra_reg;
        w_rw_raw = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_reg_write = w_rw_raw && (w_dest != 5'd0);
  assign w_imm       = w_zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

  // A same-cycle writeback to a source both satisfies the hazard and supplies the operand.
  wire logic w_rs_hit = c_bypass && wb_valid && (wb_reg == w_rs) && (w_rs != 5'd0);
  wire logic w_rt_hit = c_bypass && wb_valid && (wb_reg == w_rt) && (w_rt != 5'd0);
  wire logic w_haz_rs = w_use_rs && (w_rs != 5'd0) && r_pending[w_rs] && !w_rs_hit;
  wire logic w_haz_rt = w_use_rt && (w_rt != 5'd0) && r_pending[w_rt] && !w_rt_hit;
  wire logic w_hazard = w_haz_rs || w_haz_rt;

  wire logic w_ready  = (!r_id_valid || id_ready) && !w_hazard;
  wire logic w_accept = instr_valid && w_ready;

  // Clear is applied before set so an accept wins a same-register collision.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wb_valid) w_pending_nxt[wb_reg] = 1'b0;
    if (w_accept && w_reg_write) w_pending_nxt[w_dest] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid  <= 1'b0;
      r_opcode    <= 6'd0;
      r_funct     <= 6'd0;
      r_rs_data   <= 32'd0;
      r_rt_data   <= 32'd0;
      r_imm       <= 32'd0;
      r_dest      <= 5'd0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
      r_pending   <= 32'd0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        r_id_valid  <= 1'b1;
        r_opcode    <= w_opcode;
        r_funct     <= w_funct;
        r_rs_data   <= w_rs_hit ? wb_data : read_data_1;
        r_rt_data   <= w_rt_hit ? wb_data : read_data_2;
        r_imm       <= w_imm;
        r_dest      <= w_dest;
        r_reg_write <= w_reg_write;
        r_illegal   <= w_illegal;
      end else if (id_ready) begin
        r_id_valid  <= 1'b0;
      end
    end
  end

  assign instr_ready      = w_ready;
  assign read_reg_1       = w_rs;
  assign read_reg_2       = w_rt;
  assign write_reg        = wb_reg;
  assign write_data       = wb_data;
  assign signal_reg_write = wb_valid && (wb_reg != 5'd0);

  assign id_valid     = r_id_valid;
  assign id_opcode    = r_opcode;
  assign id_funct     = r_funct;
  assign id_rs_data   = r_rs_data;
  assign id_rt_data   = r_rt_data;
  assign id_imm       = r_imm;
  assign id_dest      = r_dest;
  assign id_reg_write = r_reg_write;
  assign id_illegal   = r_illegal;

endmodule

`default_nettype wire

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
- Instruction-decode stage directly upstream of mips_registers.
- Accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses from the instruction fields.
- Owns the register-file write port: forwards writeback results into it.
- Keeps a pending-write scoreboard that stalls RAW hazards, and registers the decoded operands into a one-entry output stage for execute.

Parameters:
- BYPASS_EN, 1: when 1, same-cycle writeback data bypasses the register file into captured operands and clears the hazard.
- RA_REG, 31: destination register for jal.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  fetch presents an instruction.
- instr  input  32  instruction word.
- instr_ready  output  1  decode accepts instr this cycle.
- read_reg_1  output  5  to regfile; instr[25:21] (rs).
- read_reg_2  output  5  to regfile; instr[20:16] (rt).
- read_data_1  input  32  from regfile.
- read_data_2  input  32  from regfile.
- wb_valid  input  1  writeback stage retires a result.
- wb_reg  input  5  writeback destination.
- wb_data  input  32  writeback value.
- write_reg  output  5  to regfile; equals wb_reg.
- write_data  output  32  to regfile; equals wb_data.
- signal_reg_write  output  1  to regfile; wb_valid && wb_reg!=0.
- id_valid  output  1  decoded instruction held for execute.
- id_ready  input  1  execute consumes id_* this cycle.
- id_opcode  output  6  instr[31:26].
- id_funct  output  6  instr[5:0].
- id_rs_data  output  32  operand A.
- id_rt_data  output  32  operand B.
- id_imm  output  32  sign-extended instr[15:0]; zero-extended for andi/ori.
- id_dest  output  5  destination register.
- id_reg_write  output  1  instruction writes id_dest.
- id_illegal  output  1  unknown opcode.

Behaviour:
- Reset (async, rst_n=0): id_valid=0; all id_* data outputs=0; scoreboard pending[31:0]=0. Register-file pass-through outputs stay combinational.
- Decode (combinational from instr):
  - opcode 0x00: srcs rs,rt; dest rd[15:11]; reg_write=1, except funct 0x08 (jr), which has reg_write=0 and src rs only.
  - 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x0C andi, 0x0D ori, 0x0F lui, 0x23 lw: src rs (lui: none); dest rt; reg_write=1.
  - 0x2B sw, 0x04 beq, 0x05 bne: srcs rs,rt; reg_write=0.
  - 0x02 j: no srcs; reg_write=0.
  - 0x03 jal: dest RA_REG; reg_write=1.
  - Any other opcode: id_illegal=1, reg_write=0, no srcs.
- Effective reg_write is forced 0 when dest=0; register 0 is never pending.
- Hazard: a used source s!=0 with pending[s]=1. With BYPASS_EN=1, the hazard is cleared if wb_valid && wb_reg==s in the same cycle.
- instr_ready = (!id_valid || id_ready) && !hazard. It does not depend on instr_valid.
- Accept = instr_valid && instr_ready. On the accept edge:
  - id_* registered, id_valid=1; latency 1 cycle.
  - Operand = wb_data if BYPASS_EN && wb_valid && wb_reg==src && src!=0; else read_data_x.
- If id_ready && !accept: id_valid falls to 0.
- Output is held stable while id_valid && !id_ready.
- Scoreboard, per edge:
  - wb_valid clears pending[wb_reg].
  - An accepted instruction with reg_write sets pending[dest].
  - Set and clear on the same register in the same cycle: set wins.
- wb_valid for a non-pending register is a harmless clear.
- Back-to-back accepts must be sustained at 1 per cycle when there is no hazard and id_ready=1.

Test Plan:
- Reset then idle: rst_n low mid-run with id_valid=1 and pending[5]=1 -> id_valid=0 immediately, pending cleared; next addi $6,$5,1 is accepted without stall.
- Independent stream: addi $1,$0,7 then addi $2,$0,-3, with id_ready=1 -> both accepted on consecutive cycles; id_imm=0x00000007 then 0xFFFFFFFD; id_dest=1 then 2.
- RAW stall: accept addi $3,$0,1; present add $4,$3,$3 with no wb -> instr_ready=0; wb_valid=1, wb_reg=3, wb_data=0x11 -> accepted that cycle with id_rs_data=id_rt_data=0x11; signal_reg_write=1, write_reg=3.
- Back-pressure: id_ready=0 with id_valid=1 -> instr_ready=0 and id_* unchanged for 3 cycles; id_ready=1 -> next instr accepted.
- Zero register and special ops: addi $0,$0,5 -> id_reg_write=0, pending[0] stays 0; jal -> id_dest=31; ori $7,$0,0x8000 -> id_imm=0x00008000; opcode 0x3F -> id_illegal=1.
- Set/clear collision: wb_valid clears reg 9 in the same cycle as lw $9 is accepted -> pending[9]=1 afterwards; a dependent add $10,$9,$0 stalls.
